// File: rtl/nachi_pkg.sv
// Shared register-file constants and writeback types.
package nachi_pkg;

  localparam int RF_AW   = 5;
  localparam int RF_DW   = 32;
  localparam int RF_NREG = 1 << RF_AW;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } wb_state_t;

  typedef logic [RF_AW-1:0] rf_idx_t;

endpackage

// File: rtl/rf_index_decoder.sv
// Register index to one-hot write-enable decoder; all zero when en is low.
module rf_index_decoder
  import nachi_pkg::*;
#(
  parameter int AW = RF_AW
) (
  input  logic              en,
  input  logic [AW-1:0]     idx,
  output logic [2**AW-1:0]  onehot
);

  always_comb begin
    // NOTE: default every comb output before the loop so no path leaves it unassigned (no latch).
    onehot = '0;
    for (int i = 0; i < 2**AW; i++) begin
      onehot[i] = en && (idx == AW'(i));
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter sharing the register-file write port between NREQ
// writeback requesters, with a one-entry output slot and one-hot decode.
module wb_port_arbiter
  import nachi_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int AW   = RF_AW,
  parameter int DW   = RF_DW
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*AW-1:0]  req_addr,
  input  logic [NREQ*DW-1:0]  req_data,
  input  logic                rf_busy,
  output logic                wr_en,
  output logic [AW-1:0]       wr_addr,
  output logic [DW-1:0]       wr_data,
  output logic [2**AW-1:0]    wr_onehot
);

  localparam int            PW     = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PW:0]   NREQ_L = (PW+1)'(NREQ);

  wb_state_t          state_q, state_d;
  logic [PW-1:0]      ptr_q, ptr_nxt;
  logic [PW:0]        ptr_ext, unrot_base;
  logic               can_accept, drain;
  logic [2*NREQ-1:0]  dbl_valid, dbl_pick;
  logic [NREQ-1:0]    rot_valid, rot_pick, grant;
  logic [PW-1:0]      win;
  logic [AW-1:0]      win_addr;
  logic [DW-1:0]      win_data;
  logic               xfer, load;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (load) state_d = FULL;
      FULL:  if (drain) state_d = load ? FULL : EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // FSM: outputs. rst_n gates acceptance so nothing is granted while in reset.
  always_comb begin
    wr_en      = (state_q == FULL);
    drain      = (state_q == FULL) && !rf_busy;
    can_accept = rst_n && ((state_q == EMPTY) || !rf_busy);
  end

  // ---------------------------------------------------------------------------
  // Round-robin search: rotate so ptr sits at bit 0, pick the lowest set bit,
  // then rotate the pick back to requester numbering.
  // ---------------------------------------------------------------------------
  always_comb begin
    ptr_ext    = {1'b0, ptr_q};
    unrot_base = NREQ_L - ptr_ext;
    dbl_valid  = {req_valid, req_valid};
    rot_valid  = dbl_valid[ptr_ext +: NREQ];

    rot_pick = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (rot_valid[j]) rot_pick = NREQ'(1) << j;
    end

    dbl_pick = {rot_pick, rot_pick};
    grant    = dbl_pick[unrot_base +: NREQ];
  end

  // Winner index and its payload; grant is one-hot or zero.
  always_comb begin
    win      = '0;
    win_addr = '0;
    win_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        win      = PW'(i);
        win_addr = req_addr[i*AW +: AW];
        win_data = req_data[i*DW +: DW];
      end
    end
  end

  assign req_ready = can_accept ? grant : '0;
  assign xfer      = can_accept && (|req_valid);
  // Register 0 is hardwired: the request is consumed but never occupies the slot.
  assign load      = xfer && (win_addr != '0);
  assign ptr_nxt   = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;

  // ---------------------------------------------------------------------------
  // Pointer and output slot
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (xfer) begin
      ptr_q <= ptr_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr <= '0;
      wr_data <= '0;
    end else if (load) begin
      wr_addr <= win_addr;
      wr_data <= win_data;
    end
  end

  rf_index_decoder #(
    .AW (AW)
  ) u_decoder (
    .en     (wr_en),
    .idx    (wr_addr),
    .onehot (wr_onehot)
  );

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: vector table, directed corner
// sequences and randomized traffic against a transaction-level model.
module tb_wb_port_arbiter;
  import nachi_pkg::*;

  localparam int NREQ = 4;
  localparam int AW   = RF_AW;
  localparam int DW   = RF_DW;
  localparam int NREG = 1 << AW;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*AW-1:0]  req_addr;
  logic [NREQ*DW-1:0]  req_data;
  logic                rf_busy;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [DW-1:0]       wr_data;
  logic [NREG-1:0]     wr_onehot;

  wb_port_arbiter #(
    .NREQ (NREQ),
    .AW   (AW),
    .DW   (DW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .rf_busy   (rf_busy),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_onehot (wr_onehot)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk_data(input int src, input logic [AW-1:0] a);
    return 32'hDA00_0000 | (32'(src) << 16) | 32'(a);
  endfunction

  function automatic logic [NREQ*AW-1:0] pack_addr(input int a0, input int a1, input int a2, input int a3);
    return {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
  endfunction

  task automatic drive_data();
    for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = mk_data(i, req_addr[i*AW +: AW]);
  endtask

  task automatic set_req(input int i, input int a, input logic [DW-1:0] d);
    req_addr[i*AW +: AW] = AW'(a);
    req_data[i*DW +: DW] = d;
  endtask

  function automatic logic [63:0] exp_hot(input logic en, input logic [AW-1:0] a);
    return en ? (64'd1 << a) : 64'd0;
  endfunction

  // Reference model: pending-write slot plus a round-robin start position.
  int              m_ptr;
  bit              m_full;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_data;

  function automatic int model_pick(input logic [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  typedef struct {
    logic [NREQ-1:0]     valid;
    logic                busy;
    logic [NREQ*AW-1:0]  addr;
    logic [NREQ-1:0]     exp_ready;
    logic                exp_en;
    rf_idx_t             exp_addr;
    int                  exp_src;
  } vec_t;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[11];
    int   win;
    logic [NREQ-1:0] exp_ready;

    // rotation 0,1,2,3,0 then drain, addr-0 discard, pointer and wrap-around checks
    vecs[0]  = '{4'b1111, 1'b0, pack_addr(1,2,3,4), 4'b0001, 1'b1, 5'd1, 0};
    vecs[1]  = '{4'b1111, 1'b0, pack_addr(1,2,3,4), 4'b0010, 1'b1, 5'd2, 1};
    vecs[2]  = '{4'b1111, 1'b0, pack_addr(1,2,3,4), 4'b0100, 1'b1, 5'd3, 2};
    vecs[3]  = '{4'b1111, 1'b0, pack_addr(1,2,3,4), 4'b1000, 1'b1, 5'd4, 3};
    vecs[4]  = '{4'b1111, 1'b0, pack_addr(1,2,3,4), 4'b0001, 1'b1, 5'd1, 0};
    vecs[5]  = '{4'b0000, 1'b0, pack_addr(1,2,3,4), 4'b0000, 1'b0, 5'd0, 0};
    vecs[6]  = '{4'b0010, 1'b0, pack_addr(1,0,3,4), 4'b0010, 1'b0, 5'd0, 0};
    vecs[7]  = '{4'b0110, 1'b0, pack_addr(1,2,3,4), 4'b0100, 1'b1, 5'd3, 2};
    vecs[8]  = '{4'b0101, 1'b0, pack_addr(1,2,3,4), 4'b0001, 1'b1, 5'd1, 0};
    vecs[9]  = '{4'b0101, 1'b0, pack_addr(1,2,3,4), 4'b0100, 1'b1, 5'd3, 2};
    vecs[10] = '{4'b0000, 1'b0, pack_addr(1,2,3,4), 4'b0000, 1'b0, 5'd0, 0};

    // ---------------- reset state ----------------
    rst_n     = 1'b0;
    req_valid = '1;
    rf_busy   = 1'b0;
    req_addr  = pack_addr(1,2,3,4);
    drive_data();
    #2;
    check("reset_ready", 64'(req_ready), 64'd0);
    check("reset_wr_en", 64'(wr_en), 64'd0);
    check("reset_wr_addr", 64'(wr_addr), 64'd0);
    check("reset_wr_data", 64'(wr_data), 64'd0);
    check("reset_onehot", 64'(wr_onehot), 64'd0);
    repeat (2) @(posedge clk);
    req_valid = '0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // ---------------- vector table ----------------
    foreach (vecs[r]) begin
      req_valid = vecs[r].valid;
      rf_busy   = vecs[r].busy;
      req_addr  = vecs[r].addr;
      drive_data();
      #1;
      check($sformatf("vec%0d_ready", r), 64'(req_ready), 64'(vecs[r].exp_ready));
      @(posedge clk); #1;
      check($sformatf("vec%0d_wr_en", r), 64'(wr_en), 64'(vecs[r].exp_en));
      check($sformatf("vec%0d_onehot", r), 64'(wr_onehot), exp_hot(vecs[r].exp_en, vecs[r].exp_addr));
      if (vecs[r].exp_en) begin
        check($sformatf("vec%0d_wr_addr", r), 64'(wr_addr), 64'(vecs[r].exp_addr));
        check($sformatf("vec%0d_wr_data", r), 64'(wr_data),
              64'(mk_data(vecs[r].exp_src, vecs[r].exp_addr)));
      end
    end

    // ---------------- rf_busy stall (slot empty, ptr=3) ----------------
    req_valid = 4'b0001;
    set_req(0, 7, 32'hDEAD_BEEF);
    #1 check("stall_load_ready", 64'(req_ready), 64'b0001);
    @(posedge clk); #1;
    check("stall_load_addr", 64'(wr_addr), 64'd7);
    req_valid = 4'b0100;
    set_req(2, 9, 32'h1234_5678);
    rf_busy = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1 check($sformatf("stall%0d_ready", c), 64'(req_ready), 64'd0);
      @(posedge clk); #1;
      check($sformatf("stall%0d_wr_en", c), 64'(wr_en), 64'd1);
      check($sformatf("stall%0d_wr_addr", c), 64'(wr_addr), 64'd7);
      check($sformatf("stall%0d_wr_data", c), 64'(wr_data), 64'hDEAD_BEEF);
      check($sformatf("stall%0d_onehot", c), 64'(wr_onehot), 64'h80);
    end
    rf_busy = 1'b0;
    #1 check("unstall_ready", 64'(req_ready), 64'b0100);
    @(posedge clk); #1;
    check("unstall_wr_addr", 64'(wr_addr), 64'd9);
    check("unstall_wr_data", 64'(wr_data), 64'h1234_5678);

    // ---------------- asynchronous reset while FULL ----------------
    req_valid = 4'b1000;
    set_req(3, 31, 32'h3131_3131);
    #1 check("r31_ready", 64'(req_ready), 64'b1000);
    @(posedge clk); #1;
    check("r31_wr_addr", 64'(wr_addr), 64'd31);
    check("r31_onehot", 64'(wr_onehot), 64'h8000_0000);
    rf_busy = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_wr_en", 64'(wr_en), 64'd0);
    check("async_rst_onehot", 64'(wr_onehot), 64'd0);
    check("async_rst_wr_addr", 64'(wr_addr), 64'd0);
    check("async_rst_wr_data", 64'(wr_data), 64'd0);
    check("async_rst_ready", 64'(req_ready), 64'd0);
    req_valid = '0;
    rf_busy   = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_wr_en", 64'(wr_en), 64'd0);

    // ---------------- back-to-back from a single requester ----------------
    req_valid = 4'b1000;
    for (int k = 0; k < 5; k++) begin
      set_req(3, 5 + k, 32'hB2B0_0000 + 32'(k));
      #1 check($sformatf("b2b%0d_ready", k), 64'(req_ready), 64'b1000);
      @(posedge clk); #1;
      check($sformatf("b2b%0d_wr_en", k), 64'(wr_en), 64'd1);
      check($sformatf("b2b%0d_wr_addr", k), 64'(wr_addr), 64'(5 + k));
      check($sformatf("b2b%0d_wr_data", k), 64'(wr_data), 64'h0B2B0_0000 + 64'(k));
    end
    req_valid = '0;
    @(posedge clk); #1;
    check("b2b_drained_wr_en", 64'(wr_en), 64'd0);

    // ---------------- randomized traffic vs model ----------------
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    m_ptr  = 0;
    m_full = 1'b0;
    m_addr = '0;
    m_data = '0;
    @(posedge clk); #1;
    for (int n = 0; n < 300; n++) begin
      req_valid = NREQ'($urandom);
      rf_busy   = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < NREQ; i++) begin
        set_req(i, ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, NREG - 1)), $urandom);
      end
      win       = model_pick(req_valid);
      exp_ready = '0;
      if (win >= 0 && (!m_full || !rf_busy)) exp_ready[win] = 1'b1;
      #1 check($sformatf("rnd%0d_ready", n), 64'(req_ready), 64'(exp_ready));

      if (m_full && !rf_busy) m_full = 1'b0;
      if (exp_ready != '0) begin
        m_ptr = (win + 1) % NREQ;
        if (req_addr[win*AW +: AW] != '0) begin
          m_full = 1'b1;
          m_addr = req_addr[win*AW +: AW];
          m_data = req_data[win*DW +: DW];
        end
      end

      @(posedge clk); #1;
      check($sformatf("rnd%0d_wr_en", n), 64'(wr_en), 64'(m_full));
      check($sformatf("rnd%0d_onehot", n), 64'(wr_onehot), exp_hot(m_full, m_addr));
      if (m_full) begin
        check($sformatf("rnd%0d_wr_addr", n), 64'(wr_addr), 64'(m_addr));
        check($sformatf("rnd%0d_wr_data", n), 64'(wr_data), 64'(m_data));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
